// File: rtl/fifo_param.sv
// Single-clock FIFO with selectable registered or first-word-fall-through read,
// occupancy count, programmable almost flags and sticky overflow/underflow errors.
module fifo_param #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4,
    parameter int FWFT       = 0,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [AW:0]           count,
    output logic [AW-1:0]         wrptr,
    output logic [AW-1:0]         rdptr,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_C    = AE_THRESH[AW:0];

    // Handshake: a write is taken when wr_en & ~full, a read when rd_en & ~empty,
    // both judged on the flags before the edge; refused requests only set the
    // sticky error flags. data_out is meaningful exactly while rd_valid is high.
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_empty = (count <= AE_C);
    assign almost_full  = (count >= AF_C);

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wrptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr     <= '0;
            rdptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wrptr <= wrptr + 1'b1;
            end
            if (rd_acc) begin
                rdptr <= rdptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new error in the same cycle as clr_err survives the clear.
            overflow  <= (wr_en & full)  | (overflow  & ~clr_err);
            underflow <= (rd_en & empty) | (underflow & ~clr_err);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rdptr];
            assign rd_valid = ~empty;
        end else begin : g_registered
            logic [FIFO_WIDTH-1:0] dout_q;
            logic                  valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem[rdptr];
                    end
                end
            end

            assign data_out = dout_q;
            assign rd_valid = valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: registered and FWFT instances share one stimulus stream
// and are compared every cycle against a queue-based model of the FIFO.
module tb_fifo_param;
    localparam int W     = 8;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, clr_err;
    logic [W-1:0]  data_in;

    logic [W-1:0]  r_dout, f_dout;
    logic          r_valid, f_valid;
    logic          r_empty, f_empty, r_full, f_full;
    logic          r_ae, f_ae, r_af, f_af;
    logic [AW:0]   r_count, f_count;
    logic [AW-1:0] r_wrptr, f_wrptr, r_rdptr, f_rdptr;
    logic          r_ovf, f_ovf, r_unf, f_unf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(r_dout), .rd_valid(r_valid), .empty(r_empty), .full(r_full),
        .almost_empty(r_ae), .almost_full(r_af), .count(r_count),
        .wrptr(r_wrptr), .rdptr(r_rdptr), .overflow(r_ovf), .underflow(r_unf),
        .clr_err(clr_err)
    );

    fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(f_dout), .rd_valid(f_valid), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .wrptr(f_wrptr), .rdptr(f_rdptr), .overflow(f_ovf), .underflow(f_unf),
        .clr_err(clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, pointers as accepted-transfer totals.
    logic [W-1:0] exp_q[$];
    int           wr_total, rd_total;
    logic         exp_ovf, exp_unf, exp_rv0;
    logic [W-1:0] exp_dout0;
    bit           started = 0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            wr_total  = 0;
            rd_total  = 0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
            exp_rv0   = 1'b0;
            exp_dout0 = '0;
            started   = 1;
        end else if (started) begin
            bit was_full, was_empty, wacc, racc;
            was_full  = (exp_q.size() == DEPTH);
            was_empty = (exp_q.size() == 0);
            wacc      = wr_en && !was_full;
            racc      = rd_en && !was_empty;
            exp_rv0   = racc;
            if (racc) begin
                exp_dout0 = exp_q.pop_front();
                rd_total++;
            end
            if (wacc) begin
                exp_q.push_back(data_in);
                wr_total++;
            end
            exp_ovf = (wr_en && was_full)  || (exp_ovf && !clr_err);
            exp_unf = (rd_en && was_empty) || (exp_unf && !clr_err);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int n;
            n = exp_q.size();
            check("count",        32'(r_count), 32'(n));
            check("empty",        32'(r_empty), 32'(n == 0));
            check("full",         32'(r_full),  32'(n == DEPTH));
            check("almost_empty", 32'(r_ae),    32'(n <= AE));
            check("almost_full",  32'(r_af),    32'(n >= AF));
            check("wrptr",        32'(r_wrptr), 32'(wr_total % DEPTH));
            check("rdptr",        32'(r_rdptr), 32'(rd_total % DEPTH));
            check("overflow",     32'(r_ovf),   32'(exp_ovf));
            check("underflow",    32'(r_unf),   32'(exp_unf));
            check("reg_rd_valid", 32'(r_valid), 32'(exp_rv0));
            check("reg_data_out", 32'(r_dout),  32'(exp_dout0));
            check("fwft_count",   32'(f_count), 32'(n));
            check("fwft_wrptr",   32'(f_wrptr), 32'(wr_total % DEPTH));
            check("fwft_rdptr",   32'(f_rdptr), 32'(rd_total % DEPTH));
            check("fwft_flags",   32'({f_empty, f_full, f_ae, f_af, f_ovf, f_unf}),
                  32'({n == 0, n == DEPTH, n <= AE, n >= AF, exp_ovf, exp_unf}));
            check("fwft_rd_valid", 32'(f_valid), 32'(n != 0));
            if (n != 0) begin
                check("fwft_data_out", 32'(f_dout), 32'(exp_q[0]));
            end
        end
    end

    task automatic cycle(input logic w, input logic [W-1:0] d, input logic r,
                         input logic c, input logic rs);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        clr_err = c;
        rst     = rs;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        wr_en = 0; rd_en = 0; clr_err = 0; data_in = '0; rst = 1;
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        check("lit_reset_count", 32'(r_count), 32'd0);
        check("lit_reset_flags", 32'({r_empty, r_ae, r_full, r_af, r_ovf, r_unf}), 32'b110000);
        check("lit_reset_dout",  32'({r_valid, r_dout}), 32'h000);

        // Fill 0x00..0x1F
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, W'(i), 0, 0, 0);
            if (i == 26) check("lit_af_27", 32'(r_af), 32'd0);
            if (i == 27) check("lit_af_28", 32'(r_af), 32'd1);
        end
        check("lit_full",  32'({r_full, r_count}), 32'({1'b1, 6'd32}));
        check("lit_wrptr", 32'(r_wrptr), 32'd0);

        // Drain, each word one edge after its rd_en
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 8'h00, 1, 0, 0);
            check("lit_drain_data", 32'({r_valid, r_dout}), 32'({1'b1, W'(i)}));
            if (i == 26) check("lit_ae_5", 32'(r_ae), 32'd0);
            if (i == 27) check("lit_ae_4", 32'(r_ae), 32'd1);
        end
        check("lit_drained_empty", 32'(r_empty), 32'd1);
        cycle(0, 8'h00, 0, 0, 0);
        check("lit_valid_pulse", 32'(r_valid), 32'd0);

        // Full with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) cycle(1, W'(8'h40 + i), 0, 0, 0);
        cycle(1, 8'hEE, 1, 0, 0);
        check("lit_ovf_count", 32'(r_count), 32'd31);
        check("lit_ovf_flag",  32'(r_ovf), 32'd1);
        check("lit_ovf_head",  32'({r_valid, r_dout}), 32'h140);
        cycle(1, 8'h77, 0, 0, 0);
        cycle(1, 8'h99, 0, 1, 0);
        check("lit_set_wins", 32'(r_ovf), 32'd1);
        cycle(0, 8'h00, 0, 1, 0);
        check("lit_ovf_clear", 32'(r_ovf), 32'd0);
        cycle(0, 8'h00, 0, 0, 1);

        // Empty with simultaneous read and write
        cycle(1, 8'hA5, 1, 0, 0);
        check("lit_unf_count", 32'(r_count), 32'd1);
        check("lit_unf_flag",  32'(r_unf), 32'd1);
        check("lit_unf_valid", 32'(r_valid), 32'd0);
        check("lit_fwft_a5",   32'({f_valid, f_dout}), 32'h1A5);
        cycle(0, 8'h00, 1, 0, 0);
        check("lit_read_a5",   32'({r_valid, r_dout}), 32'h1A5);
        cycle(0, 8'h00, 0, 1, 0);
        check("lit_unf_clear", 32'(r_unf), 32'd0);

        // Fall-through of a word written into an empty FIFO
        cycle(1, 8'h3C, 0, 0, 0);
        check("lit_fwft_3c", 32'({f_valid, f_dout}), 32'h13C);
        cycle(0, 8'h00, 1, 0, 0);
        check("lit_fwft_pop", 32'({f_empty, f_valid}), 32'b10);

        // Reset mid-stream
        for (int i = 0; i < 20; i++) cycle(1, W'($urandom_range(0, 255)), 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 1);
        check("lit_mid_reset", 32'({r_count, r_wrptr, r_rdptr}), 32'd0);
        check("lit_mid_flags", 32'({r_empty, r_full, r_af, r_ovf, r_unf, r_valid}), 32'b100000);

        // Pointer wrap after reset
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 25; i++) cycle(1, W'($urandom_range(0, 255)), 0, 0, 0);
            for (int i = 0; i < 25; i++) cycle(0, 8'h00, 1, 0, 0);
        end
        check("lit_wrap_wrptr", 32'(f_wrptr), 32'd18);

        // Randomized phases with varying fill/drain bias
        for (int p = 0; p < 60; p++) begin
            int wp, rp;
            wp = $urandom_range(0, 100);
            rp = $urandom_range(0, 100);
            for (int i = 0; i < 64; i++) begin
                cycle($urandom_range(0, 99) < wp, W'($urandom_range(0, 255)),
                      $urandom_range(0, 99) < rp, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 499) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
